// File: rtl/hp_burst_master.sv
// hp_burst_master: single-outstanding AXI3 INCR burst master (1-16 beats) with stream data and status records
module hp_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    sts_valid,
  input  logic                    sts_ready,
  output logic                    sts_write,
  output logic [1:0]              sts_resp,
  output logic                    sts_err,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [ID_WIDTH-1:0]     awid,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic [ID_WIDTH-1:0]     wid,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [ID_WIDTH-1:0]     bid,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [ID_WIDTH-1:0]     arid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic                    rlast
);
  localparam int LSB = $clog2(DATA_WIDTH / 8);
  typedef enum logic [2:0] {IDLE, ADDR_W, BRESP, ADDR_R, RDATA, STATUS, REJECT} state_t;
  state_t state, state_nx;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  aw_done;
  logic                  w_done;
  logic [3:0]            w_cnt;
  logic [3:0]            r_cnt;
  logic [1:0]            resp_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_al;
  logic [13:0]           end_off;
  logic                  cmd_hs;
  assign cmd_addr_al = {cmd_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
  assign end_off = 14'(cmd_addr_al[11:0]) + ((14'(cmd_len) + 14'd1) << LSB);
  assign cmd_hs = cmd_valid & cmd_ready;
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign awlen = len_q;
  assign arlen = len_q;
  assign awid = id_q;
  assign arid = id_q;
  assign wid = id_q;
  assign awsize = 3'(LSB);
  assign arsize = 3'(LSB);
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wstrb = '1;
  assign sts_write = wr_q;
  assign sts_resp = resp_q;
  assign sts_err = err_q;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state and channel handshake outputs; W and R paths are combinational pass-throughs
  always_comb begin
    state_nx = state;
    cmd_ready = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    in_ready = 1'b0;
    wlast = 1'b0;
    wdata = '0;
    bready = 1'b0;
    arvalid = 1'b0;
    rready = 1'b0;
    out_valid = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    sts_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid & ~reset) state_nx = (end_off > 14'd4096) ? REJECT : cmd_write ? ADDR_W : ADDR_R;
      end
      ADDR_W: begin
        awvalid = ~aw_done;
        wvalid = ~w_done & in_valid;
        in_ready = ~w_done & wready;
        wlast = ~w_done & (w_cnt == len_q);
        wdata = w_done ? '0 : in_data;
        if ((aw_done | awready) & (w_done | (wvalid & wready & wlast))) state_nx = BRESP;
      end
      BRESP: begin
        bready = 1'b1;
        if (bvalid) state_nx = STATUS;
      end
      ADDR_R: begin
        arvalid = 1'b1;
        if (arready) state_nx = RDATA;
      end
      RDATA: begin
        rready = out_ready;
        out_valid = rvalid;
        out_data = rdata;
        out_last = rlast;
        if (rvalid & out_ready & (rlast | (r_cnt == len_q))) state_nx = STATUS;
      end
      REJECT: state_nx = STATUS;
      STATUS: begin
        sts_valid = 1'b1;
        if (sts_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // command latch, beat counters and status accumulation
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      id_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      w_cnt <= '0;
      r_cnt <= '0;
      resp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        wr_q <= cmd_write;
        addr_q <= cmd_addr_al;
        len_q <= cmd_len;
        id_q <= cmd_id;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        w_cnt <= '0;
        r_cnt <= '0;
        resp_q <= '0;
        err_q <= 1'b0;
      end
      if (awvalid & awready) aw_done <= 1'b1;
      if (wvalid & wready) begin
        if (wlast) w_done <= 1'b1;
        else w_cnt <= w_cnt + 4'd1;
      end
      if (bready & bvalid) begin
        resp_q <= bresp;
        err_q <= (bid != id_q);
      end
      if (rready & rvalid) begin
        r_cnt <= r_cnt + 4'd1;
        resp_q <= (rresp > resp_q) ? rresp : resp_q;
        err_q <= err_q | (rid != id_q) | (rlast != (r_cnt == len_q));
      end
      if (state == REJECT) begin
        err_q <= 1'b1;
        resp_q <= 2'b00;
      end
    end
endmodule

// File: tb/tb_hp_burst_master.sv
// tb_hp_burst_master: directed and randomized commands against an AXI slave model and a burst-level reference model
module tb_hp_burst_master;
  typedef struct packed {logic [31:0] d; logic [1:0] resp; logic [5:0] id; logic last;} rbeat_t;
  logic clock = 0;
  logic reset = 1;
  logic cmd_valid = 0, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [3:0] cmd_len = 0;
  logic [5:0] cmd_id = 0;
  logic cmd_ready;
  logic [31:0] in_data = 0;
  logic in_valid = 0, in_ready;
  logic [31:0] out_data;
  logic out_valid, out_last, out_ready = 0;
  logic sts_valid, sts_ready = 0, sts_write, sts_err;
  logic [1:0] sts_resp;
  logic awvalid, awready = 0;
  logic [31:0] awaddr;
  logic [3:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [5:0] awid;
  logic wvalid, wready = 0, wlast;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [5:0] wid;
  logic bvalid = 0, bready;
  logic [1:0] bresp = 0;
  logic [5:0] bid = 0;
  logic arvalid, arready = 0;
  logic [31:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [5:0] arid;
  logic rvalid = 0, rready, rlast = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0;
  logic [5:0] rid = 0;

  int n_assert = 0, n_fail = 0;
  int aw_delay = 0, b_lat = 0, wr_pct = 100, iv_pct = 100, rv_pct = 100, or_mode = 0;
  logic [1:0] b_resp_cfg = 0;
  logic [5:0] b_id_cfg = 0, cur_id = 0;
  int aw_wait = 0, b_wait = 0, aw_hs_n = 0, ar_hs_n = 0, wlast_n = 0, wlast_at = -1, w_bad = 0, quiet_bad = 0;
  bit b_done = 0, cmd_seen = 0, sts_seen = 0, quiet = 0;
  logic [31:0] aw_addr_s, ar_addr_s;
  logic [3:0] aw_len_s, ar_len_s;
  logic [5:0] aw_id_s, ar_id_s;
  logic sts_w_s, sts_err_s;
  logic [1:0] sts_resp_s;
  logic [31:0] in_q[$], w_got[$], exp_w[$], out_got[$];
  logic outl_got[$];
  rbeat_t r_q[$], sent[$];

  hp_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(6)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_write(sts_write), .sts_resp(sts_resp), .sts_err(sts_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  always #5 clock = ~clock;

  // slave and stream sources: update just after each rising edge
  always begin
    @(posedge clock); #1;
    aw_wait = awvalid ? aw_wait + 1 : 0;
    awready = awvalid && aw_wait > aw_delay;
    wready = $urandom_range(99) < wr_pct;
    in_valid = in_q.size() > 0 && $urandom_range(99) < iv_pct;
    in_data = in_q.size() > 0 ? in_q[0] : 32'h0;
    b_wait = (aw_hs_n > 0 && wlast_n > 0 && !b_done) ? b_wait + 1 : 0;
    bvalid = b_wait > b_lat;
    bresp = b_resp_cfg;
    bid = b_id_cfg;
    arready = arvalid && $urandom_range(1) == 1;
    rvalid = ar_hs_n > 0 && r_q.size() > 0 && $urandom_range(99) < rv_pct;
    {rdata, rresp, rid, rlast} = r_q.size() > 0 ? r_q[0] : '0;
    out_ready = or_mode == 0 ? 1'b1 : or_mode == 1 ? !out_ready : 1'($urandom_range(1));
    sts_ready = $urandom_range(1) == 1;
  end

  // handshake monitor: samples on the falling edge what the next rising edge will transfer
  always begin
    @(negedge clock);
    if (!reset) begin
      if (cmd_valid && cmd_ready) cmd_seen = 1;
      if (awvalid && awready) begin
        aw_hs_n++;
        aw_addr_s = awaddr; aw_len_s = awlen; aw_id_s = awid;
      end
      if (wvalid && wready) begin
        w_got.push_back(wdata);
        if (wlast) begin wlast_n++; wlast_at = w_got.size() - 1; end
        if (wid !== cur_id || wstrb !== 4'hF) w_bad++;
      end
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (bvalid && bready) b_done = 1;
      if (arvalid && arready) begin
        ar_hs_n++;
        ar_addr_s = araddr; ar_len_s = arlen; ar_id_s = arid;
      end
      if (out_valid && out_ready) begin out_got.push_back(out_data); outl_got.push_back(out_last); end
      if (rvalid && rready) void'(r_q.pop_front());
      if (sts_valid && sts_ready) begin
        sts_seen = 1; sts_w_s = sts_write; sts_resp_s = sts_resp; sts_err_s = sts_err;
      end
      if (quiet && (awvalid || arvalid || wvalid || in_ready || out_valid || rready || bready)) quiet_bad++;
    end
  end

  function automatic bit crosses(input logic [31:0] a, input logic [3:0] l);
    return (int'(a[11:2]) * 4 + (int'(l) + 1) * 4) > 4096;
  endfunction

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_slave();
    aw_hs_n = 0; ar_hs_n = 0; b_done = 0; wlast_n = 0; wlast_at = -1; w_bad = 0; quiet_bad = 0;
    cmd_seen = 0; sts_seen = 0; quiet = 0;
    in_q.delete(); w_got.delete(); exp_w.delete(); out_got.delete(); outl_got.delete(); r_q.delete(); sent.delete();
  endtask

  task automatic rst_checks();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_w_side", {awvalid, wvalid, wlast, bready, in_ready}, 0);
    chk("rst_r_side", {arvalid, rready, out_valid, out_last}, 0);
    chk("rst_status", {sts_valid, sts_write, sts_err, sts_resp}, 0);
    chk("rst_aw_fields", {awaddr, awlen, awid, wid}, 0);
    chk("rst_ar_fields", {araddr, arlen, arid}, 0);
    chk("rst_data", {wdata, out_data}, 0);
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [3:0] l, input logic [5:0] id, input bit rej);
    cur_id = id;
    @(posedge clock); #2;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    for (int i = 0; i < 50 && !cmd_seen; i++) begin @(negedge clock); #1; end
    chk("cmd_hs", cmd_seen, 1);
    @(posedge clock); #2;
    cmd_valid = 0; cmd_write = !wr; cmd_addr = $urandom; cmd_len = 4'($urandom); cmd_id = 6'($urandom);
    @(negedge clock); #1;
    chk("aw_next_cycle", awvalid, wr && !rej);
    chk("ar_next_cycle", arvalid, !wr && !rej);
    chk("cmd_busy", cmd_ready, 0);
  endtask

  task automatic wait_sts();
    for (int i = 0; i < 600 && !sts_seen; i++) begin @(negedge clock); #1; end
    chk("sts_seen", sts_seen, 1);
    @(negedge clock); #1;
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  // one command end to end; rp packs per-beat responses (2 bits each), bad = beat with a wrong id,
  // last_at = beat carrying rlast (greater than len means rlast never comes)
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                        input logic [31:0] rp, input int bad, input int last_at);
    bit rej, exp_err;
    int nb, bad_n;
    logic [1:0] exp_resp;
    logic [31:0] w;
    rbeat_t b;
    rej = crosses(addr, len);
    clear_slave();
    quiet = rej;
    exp_resp = 0;
    exp_err = rej;
    nb = 0;
    if (wr) begin
      for (int i = 0; i <= int'(len) + 1; i++) begin
        w = $urandom;
        in_q.push_back(w);
        if (i <= int'(len)) exp_w.push_back(w);
      end
      b_resp_cfg = rp[1:0];
      b_id_cfg = bad >= 0 ? id ^ 6'd1 : id;
      if (!rej) begin exp_resp = rp[1:0]; exp_err = bad >= 0; end
    end else begin
      nb = last_at <= int'(len) ? last_at + 1 : int'(len) + 1;
      for (int i = 0; i < nb; i++) begin
        b.d = $urandom; b.resp = rp[2*i +: 2]; b.id = i == bad ? id ^ 6'd1 : id; b.last = i == last_at;
        sent.push_back(b);
        if (!rej) begin
          if (b.resp > exp_resp) exp_resp = b.resp;
          if (i == bad) exp_err = 1;
        end
      end
      if (!rej) begin
        if (last_at != int'(len)) exp_err = 1;
        r_q = sent;
      end
    end
    issue(wr, addr, len, id, rej);
    wait_sts();
    quiet = 0;
    chk("sts_write", sts_w_s, wr);
    chk("sts_resp", sts_resp_s, exp_resp);
    chk("sts_err", sts_err_s, exp_err);
    chk("reject_quiet", quiet_bad, 0);
    if (wr) begin
      chk("aw_count", aw_hs_n, rej ? 0 : 1);
      chk("w_beats", w_got.size(), rej ? 0 : int'(len) + 1);
      chk("in_left", in_q.size(), rej ? int'(len) + 2 : 1);
      if (!rej) begin
        chk("awaddr", aw_addr_s, {addr[31:2], 2'b00});
        chk("awlen", aw_len_s, len);
        chk("awid", aw_id_s, id);
        chk("wlast_count", wlast_n, 1);
        chk("wlast_beat", wlast_at, len);
        bad_n = 0;
        foreach (exp_w[i]) if (i >= w_got.size() || w_got[i] !== exp_w[i]) bad_n++;
        chk("wdata", bad_n, 0);
        chk("wid_wstrb", w_bad, 0);
      end
    end else begin
      chk("ar_count", ar_hs_n, rej ? 0 : 1);
      chk("out_beats", out_got.size(), rej ? 0 : nb);
      if (!rej) begin
        chk("araddr", ar_addr_s, {addr[31:2], 2'b00});
        chk("arlen", ar_len_s, len);
        chk("arid", ar_id_s, id);
        chk("r_left", r_q.size(), 0);
        bad_n = 0;
        foreach (sent[i]) if (i >= out_got.size() || out_got[i] !== sent[i].d || outl_got[i] !== sent[i].last) bad_n++;
        chk("out_data_last", bad_n, 0);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0] l;
    int bad, la;
    repeat (3) @(negedge clock);
    #1;
    rst_checks();
    @(posedge clock); #2;
    reset = 0;
    @(negedge clock); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);
    chk("const_aw", {awsize, awburst, wstrb}, {3'd2, 2'b01, 4'hF});
    chk("const_ar", {arsize, arburst}, {3'd2, 2'b01});
    // write, everything ready
    do_cmd(1, 32'h1000_0004, 3, 6'd5, 0, -1, 3);
    // long read with out_ready toggling every cycle
    or_mode = 1;
    do_cmd(0, 32'h2000_0000, 15, 6'h07, 0, -1, 15);
    or_mode = 0;
    // worst-case response across beats: 0,2,0,3
    do_cmd(0, 32'h2000_0040, 3, 6'h09, 32'hC8, -1, 3);
    // AW accepted well after all W beats
    aw_delay = 5;
    do_cmd(1, 32'h1000_0100, 3, 6'h0C, 0, -1, 3);
    aw_delay = 0;
    // 4 KB boundary: crossing rejected, exact fit accepted
    do_cmd(1, 32'h0000_0FF8, 3, 6'h01, 0, -1, 3);
    do_cmd(0, 32'h3000_0FC4, 15, 6'h02, 0, -1, 15);
    do_cmd(0, 32'h3000_0FC0, 15, 6'h03, 0, -1, 15);
    // error paths: bad bid with SLVERR, early rlast, missing rlast, bad rid
    do_cmd(1, 32'h4000_0010, 1, 6'h15, 32'h2, 0, 1);
    do_cmd(0, 32'h4000_0100, 5, 6'h16, 0, -1, 2);
    do_cmd(0, 32'h4000_0200, 2, 6'h17, 0, -1, 16);
    do_cmd(0, 32'h4000_0300, 3, 6'h18, 32'h10, 1, 3);
    // reset in the middle of a read burst
    clear_slave();
    cur_id = 6'h2A;
    for (int i = 0; i < 4; i++) r_q.push_back({32'($urandom), 2'b00, 6'h2A, 1'(i == 3)});
    issue(0, 32'h2000_0100, 3, 6'h2A, 0);
    for (int i = 0; i < 200 && out_got.size() < 2; i++) begin @(negedge clock); #1; end
    chk("pre_reset_beats", out_got.size(), 2);
    @(posedge clock); #2;
    reset = 1;
    @(negedge clock); #1;
    rst_checks();
    clear_slave();
    @(posedge clock); #2;
    reset = 0;
    @(negedge clock); #1;
    chk("cmd_ready_after_midreset", cmd_ready, 1);
    do_cmd(0, 32'h2000_0200, 0, 6'h11, 0, -1, 0);
    // randomized commands
    for (int k = 0; k < 24; k++) begin
      aw_delay = $urandom_range(3); b_lat = $urandom_range(4);
      wr_pct = 50 + $urandom_range(50); iv_pct = 50 + $urandom_range(50); rv_pct = 50 + $urandom_range(50);
      or_mode = $urandom_range(2);
      a = $urandom;
      if ($urandom_range(2) == 0) a[11:0] = 12'hFC0 + 12'($urandom_range(63));
      l = 4'($urandom_range(15));
      bad = $urandom_range(5) == 0 ? int'($urandom_range(int'(l))) : -1;
      la = $urandom_range(5) == 0 ? int'($urandom_range(16)) : int'(l);
      do_cmd(1'($urandom_range(1)), a, l, 6'($urandom), $urandom, bad, la);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
